// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV core: per-stage stall/flush from load-use, jumps,
// mul/div and LS memory waits, with a wait-state FSM, perf counters and a sticky memory timeout.
module hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_idx_id,
    input  logic [4:0]       rs2_idx_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_idx_ex,
    input  logic             wben_ex,
    input  logic             is_load_ex,
    input  logic             is_jump_ex,
    input  logic             md_busy_ex,
    input  logic             md_done_ex,
    input  logic             mem_req_ls,
    input  logic             mem_ack_ls,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_ls_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_ls_o,
    output logic             flush_wb_o,
    output logic [1:0]       state_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MD_WAIT  = 2'd2;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_inc;
    logic            lu;
    logic            memw;
    logic            mdw;
    logic            jump_flush;
    logic [7:0]      ctrl;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] v);
        return (&v) ? v : v + TO_W'(1);
    endfunction

    always_comb begin
        lu   = is_load_ex & wben_ex & (rd_idx_ex != 5'd0) &
               ((rs1_used_id & (rs1_idx_id == rd_idx_ex)) |
                (rs2_used_id & (rs2_idx_id == rd_idx_ex)));
        memw = mem_req_ls & ~mem_ack_ls;
        mdw  = md_busy_ex & ~md_done_ex;
    end

    // ctrl = {stall_if, stall_id, stall_ex, stall_ls, flush_id, flush_ex, flush_ls, flush_wb}
    always_comb begin
        ctrl       = 8'b0000_0000;
        jump_flush = 1'b0;
        if (!rst_n) begin
            ctrl = 8'b0000_1111;
        end else if (memw) begin
            ctrl = 8'b1111_0001;
        end else if (mdw) begin
            ctrl = 8'b1110_0010;
        end else if (is_jump_ex) begin
            ctrl       = 8'b0000_1100;
            jump_flush = 1'b1;
        end else if (lu) begin
            ctrl = 8'b1100_0100;
        end
    end

    assign {stall_if_o, stall_id_o, stall_ex_o, stall_ls_o,
            flush_id_o, flush_ex_o, flush_ls_o, flush_wb_o} = ctrl;

    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN: begin
                if (memw)     state_nxt = ST_MEM_WAIT;
                else if (mdw) state_nxt = ST_MD_WAIT;
            end
            ST_MEM_WAIT: begin
                if (!mem_ack_ls) state_nxt = ST_MEM_WAIT;
                else if (mdw)    state_nxt = ST_MD_WAIT;
            end
            ST_MD_WAIT: begin
                // An LS access stuck behind the mul/div takes over the wait.
                if (memw)             state_nxt = ST_MEM_WAIT;
                else if (!md_done_ex) state_nxt = ST_MD_WAIT;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign to_cnt_inc = sat_inc_to(to_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            to_cnt      <= '0;
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_MEM_WAIT) begin
                to_cnt <= (state_nxt == ST_MEM_WAIT) ? to_cnt_inc : '0;
                if (to_cnt_inc >= TO_LIMIT) mem_err_o <= 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (stall_if_o) stall_cnt_o <= sat_inc_cnt(stall_cnt_o);
            if (jump_flush) flush_cnt_o <= sat_inc_cnt(flush_cnt_o);
        end
    end

    assign state_o = state;

endmodule
